qspi_master_tx: RTL and testbench

- Host-side (initiator) serial master for the FPGA's QSPI slave link: drives chip-select, serial clock and the host-to-FPGA data line, and samples the FPGA-to-host data line.
- Byte-stream interface: accepts bytes over a valid/ready handshake, returns one received byte per transmitted byte, and frames transfers under one chip-select.
- Used as the bench/loopback partner of the slave rx/tx pair and as a master for on-board SPI peripherals.
- SPI mode 0: SCK idles low, data changes on the falling edge, data is sampled on the rising edge, MSB first, single-bit data lines.

---
 rtl/qspi_master_tx.sv | 223 ++++++++++++++++++++++
 tb/tb_qspi_master_tx.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_master_tx.sv
// qspi_master_tx
//   Host-side SPI mode-0 master for the FPGA QSPI slave link. It takes bytes
//   over a valid/ready handshake and shifts each one out MSB first on mosi.
//   At the same time it shifts a byte in from miso and returns it with a
//   one-cycle rx_valid pulse. All bytes up to and including the one flagged
//   tx_last are framed under a single cs_n assertion.
//
// Ports
//   clk       : system clock, all logic on the rising edge
//   reset_n   : asynchronous active-low reset
//   tx_data   : byte to transmit
//   tx_last   : release chip-select after this byte
//   tx_valid  : tx_data/tx_last are valid
//   tx_ready  : a byte is accepted this cycle when tx_valid is also high
//   rx_data   : last received byte, held until the next rx_valid
//   rx_valid  : one-cycle pulse marking a new rx_data
//   busy      : chip-select low or inter-frame gap in progress
//   sck       : serial clock, idles low
//   cs_n      : chip select, active low
//   mosi      : serial data out
//   miso      : serial data in
module qspi_master_tx #(
  parameter int CLK_DIV  = 2,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_GAP   = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       sck,
  output logic       cs_n,
  output logic       mosi,
  input  logic       miso
);

  localparam int DIV_W    = $clog2(CLK_DIV + 1);
  localparam int WAIT_MAX = (CS_SETUP > CS_HOLD)
                            ? ((CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP)
                            : ((CS_HOLD  > CS_GAP) ? CS_HOLD  : CS_GAP);
  localparam int WAIT_W   = $clog2(WAIT_MAX + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [WAIT_W-1:0] SETUP_LAST = WAIT_W'(CS_SETUP - 1);
  localparam logic [WAIT_W-1:0] HOLD_LAST  = WAIT_W'(CS_HOLD - 1);
  localparam logic [WAIT_W-1:0] GAP_LAST   = WAIT_W'(CS_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_LO,
    S_HI,
    S_NEXT,
    S_HOLD,
    S_GAP
  } state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic [DIV_W-1:0]    r_divCnt;
  logic [WAIT_W-1:0]   r_waitCnt;
  logic [WAIT_W-1:0]   w_waitLimit;
  logic [2:0]          r_bitCnt;
  logic [7:0]          r_txShift;
  logic [7:0]          r_rxShift;
  logic [7:0]          r_rxData;
  logic                r_rxValid;
  logic                r_last;
  logic                r_armed;
  logic                w_divDone;
  logic                w_waitDone;
  logic                w_lastBit;
  logic                w_accept;

  // The current MSB of the transmit shift register is the bit on the wire.
  // Loading a byte or shifting is therefore the only way mosi changes, and
  // both happen while sck is low.
  assign mosi     = r_txShift[7];
  assign rx_data  = r_rxData;
  assign rx_valid = r_rxValid;

  // SETUP, HOLD and GAP share one wait counter. Only the terminal count
  // depends on which of those states is active.
  always_comb begin
    w_waitLimit = GAP_LAST;
    case (r_state)
      S_SETUP: w_waitLimit = SETUP_LAST;
      S_HOLD:  w_waitLimit = HOLD_LAST;
      default: w_waitLimit = GAP_LAST;
    endcase
  end

  assign w_divDone  = (r_divCnt == DIV_LAST);
  assign w_waitDone = (r_waitCnt == w_waitLimit);
  assign w_lastBit  = (r_bitCnt == 3'd0);
  assign w_accept   = tx_valid & tx_ready;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic and the state-decoded link outputs. tx_ready is a pure
  // function of state, so it never loops back through tx_valid. The final
  // byte of a frame goes straight from HI to HOLD. This keeps the cs_n-low
  // window at exactly setup + byte time + hold.
  always_comb begin
    w_nextState = r_state;
    tx_ready    = 1'b0;
    sck         = 1'b0;
    cs_n        = 1'b1;
    busy        = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy     = 1'b0;
        tx_ready = r_armed;
        if (w_accept) w_nextState = S_SETUP;
      end
      S_SETUP: begin
        cs_n = 1'b0;
        if (w_waitDone) w_nextState = S_LO;
      end
      S_LO: begin
        cs_n = 1'b0;
        if (w_divDone) w_nextState = S_HI;
      end
      S_HI: begin
        cs_n = 1'b0;
        sck  = 1'b1;
        if (w_divDone) begin
          if (!w_lastBit)  w_nextState = S_LO;
          else if (r_last) w_nextState = S_HOLD;
          else             w_nextState = S_NEXT;
        end
      end
      S_NEXT: begin
        cs_n     = 1'b0;
        tx_ready = !r_last;
        if (r_last)        w_nextState = S_HOLD;
        else if (tx_valid) w_nextState = S_LO;
      end
      S_HOLD: begin
        cs_n = 1'b0;
        if (w_waitDone) w_nextState = S_GAP;
      end
      S_GAP: begin
        if (w_waitDone) w_nextState = S_IDLE;
      end
      default: begin
        busy        = 1'b0;
        w_nextState = S_IDLE;
      end
    endcase
  end

  // Phase counters. Each counter runs only inside the states that use it and
  // sits at zero otherwise. Every phase therefore starts counting from zero
  // on entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_divCnt  <= '0;
      r_waitCnt <= '0;
    end else begin
      if ((r_state == S_LO || r_state == S_HI) && !w_divDone) begin
        r_divCnt <= r_divCnt + 1'b1;
      end else begin
        r_divCnt <= '0;
      end
      if ((r_state == S_SETUP || r_state == S_HOLD || r_state == S_GAP) && !w_waitDone) begin
        r_waitCnt <= r_waitCnt + 1'b1;
      end else begin
        r_waitCnt <= '0;
      end
    end
  end

  // Shift datapath. A byte is loaded on any accepted handshake (IDLE or
  // NEXT). miso is captured on the edge that raises sck. The next tx bit is
  // presented on the edge that drops sck. After the eighth bit the received
  // byte is published with a single-cycle strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_armed   <= 1'b0;
      r_txShift <= '0;
      r_rxShift <= '0;
      r_rxData  <= '0;
      r_rxValid <= 1'b0;
      r_last    <= 1'b0;
      r_bitCnt  <= '0;
    end else begin
      r_armed   <= 1'b1;
      r_rxValid <= 1'b0;
      if (w_accept) begin
        r_txShift <= tx_data;
        r_last    <= tx_last;
        r_bitCnt  <= 3'd7;
      end
      if (r_state == S_LO && w_divDone) begin
        r_rxShift <= {r_rxShift[6:0], miso};
      end
      if (r_state == S_HI && w_divDone) begin
        if (!w_lastBit) begin
          r_bitCnt  <= r_bitCnt - 1'b1;
          r_txShift <= {r_txShift[6:0], 1'b0};
        end else begin
          r_rxData  <= r_rxShift;
          r_rxValid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_qspi_master_tx.sv
// tb_qspi_master_tx
//   Self-checking bench for qspi_master_tx. Frames are described as byte
//   lists with stalls, start delays and a miso source. An expected waveform
//   for every cycle is derived from them with plain timing arithmetic. A
//   single compare process checks the DUT against that waveform on each
//   falling clock edge. A few directly measured literals (frame length,
//   edge spacing, received bytes) pin the model.
module tb_qspi_master_tx;

  localparam int D   = 2;
  localparam int CSS = 2;
  localparam int CSH = 2;
  localparam int CSG = 4;
  localparam int NC  = 4096;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [7:0] tx_data = '0;
  logic       tx_last = 1'b0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       sck;
  logic       cs_n;
  logic       mosi;
  logic       miso;
  logic       misoDrv = 1'b0;
  logic       loopSel = 1'b0;

  assign miso = loopSel ? mosi : misoDrv;

  always #5 clk = ~clk;

  qspi_master_tx #(
    .CLK_DIV (D),
    .CS_SETUP(CSS),
    .CS_HOLD (CSH),
    .CS_GAP  (CSG)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .tx_data (tx_data),
    .tx_last (tx_last),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .busy    (busy),
    .sck     (sck),
    .cs_n    (cs_n),
    .mosi    (mosi),
    .miso    (miso)
  );

  typedef struct {
    int               n;
    int               delay;
    int               mode;
    logic [2:0][7:0]  txb;
    logic [2:0][7:0]  rxb;
    logic [2:0][7:0]  stall;
  } frame_t;

  frame_t frames [$];

  logic       eCs [NC];
  logic       eSck [NC];
  logic       eRdy [NC];
  logic       eBusy [NC];
  logic       eRxv [NC];
  logic [7:0] eRxNew [NC];
  logic [7:0] eRxd [NC];
  logic       eMosiChk [NC];
  logic       eMosi [NC];
  logic       dValid [NC];
  logic [7:0] dData [NC];
  logic       dLast [NC];
  logic       dMiso [NC];
  logic       dLoop [NC];
  logic       aCs [NC];
  logic       aSck [NC];
  logic [7:0] rxSeen [$];

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  logic checkEn = 1'b0;
  logic recA = 1'b0;
  logic prevMosi = 1'b0;

  task automatic checkOutput(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s cycle=%0d got=%0h want=%0h", name, c, act, exp);
    end
  endtask

  task automatic pushFrame(input int n, input int delay, input int mode,
                           input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input int s0, input int s1);
    frame_t f;
    f.n      = n;
    f.delay  = delay;
    f.mode   = mode;
    f.txb[0] = b0;
    f.txb[1] = b1;
    f.txb[2] = b2;
    f.stall[0] = 8'(s0);
    f.stall[1] = 8'(s1);
    f.stall[2] = 8'd0;
    for (int k = 0; k < 3; k++) begin
      if (mode == 0)      f.rxb[k] = f.txb[k];
      else if (mode == 2) f.rxb[k] = 8'hFF;
      else                f.rxb[k] = 8'($urandom);
    end
    frames.push_back(f);
  endtask

  // Turns the queued frames into a per-cycle expected waveform plus the
  // input drive schedule. Cycle a carries the accepted byte. cs_n falls at
  // a+1. Bit i of a byte starting at l occupies [l+2Di, l+2D(i+1)) with sck
  // high in the second half. A byte ends 16D cycles after it starts.
  task automatic buildTimeline(input logic [7:0] startRx, output int len);
    int t, a, l, e, h, s, c;
    logic [7:0] rxNow;
    for (int i = 0; i < NC; i++) begin
      eCs[i] = 1'b1; eSck[i] = 1'b0; eRdy[i] = 1'b1; eBusy[i] = 1'b0;
      eRxv[i] = 1'b0; eRxNew[i] = '0; eMosiChk[i] = 1'b0; eMosi[i] = 1'b0;
      dValid[i] = 1'b0; dData[i] = 8'($urandom); dLast[i] = 1'($urandom);
      dMiso[i] = 1'($urandom); dLoop[i] = 1'b0;
    end
    t = 0;
    foreach (frames[fi]) begin
      if (t + 400 >= NC) begin
        $display("[TB] FAIL timelineOverflow cycle=%0d got=%0d want<%0d", 0, t + 400, NC);
        $fatal(1, "[TB] timeline too long");
      end
      a = t + frames[fi].delay;
      dValid[a] = 1'b1;
      dData[a]  = frames[fi].txb[0];
      dLast[a]  = (frames[fi].n == 1);
      l = a + 1 + CSS;
      for (c = a + 1; c < l; c++) begin
        eCs[c] = 1'b0; eRdy[c] = 1'b0; eBusy[c] = 1'b1;
        eMosiChk[c] = 1'b1; eMosi[c] = frames[fi].txb[0][7];
      end
      for (int k = 0; k < frames[fi].n; k++) begin
        for (int i = 0; i < 8; i++) begin
          for (int j = 0; j < 2 * D; j++) begin
            c = l + 2 * D * i + j;
            eCs[c] = 1'b0; eRdy[c] = 1'b0; eBusy[c] = 1'b1;
            eSck[c] = (j >= D);
            eMosiChk[c] = 1'b1;
            eMosi[c] = frames[fi].txb[k][7 - i];
            if (frames[fi].mode != 0) dMiso[c] = frames[fi].rxb[k][7 - i];
          end
        end
        e = l + 16 * D;
        eRxv[e] = 1'b1;
        eRxNew[e] = frames[fi].rxb[k];
        if (k < frames[fi].n - 1) begin
          s = int'(frames[fi].stall[k]);
          for (c = e; c <= e + s; c++) begin
            eCs[c] = 1'b0; eRdy[c] = 1'b1; eBusy[c] = 1'b1;
          end
          dValid[e + s] = 1'b1;
          dData[e + s]  = frames[fi].txb[k + 1];
          dLast[e + s]  = (k + 1 == frames[fi].n - 1);
          l = e + s + 1;
        end else begin
          h = e + CSH;
          for (c = e; c < h; c++) begin
            eCs[c] = 1'b0; eRdy[c] = 1'b0; eBusy[c] = 1'b1;
          end
          for (c = h; c < h + CSG; c++) begin
            eCs[c] = 1'b1; eRdy[c] = 1'b0; eBusy[c] = 1'b1;
          end
          t = h + CSG;
        end
      end
      for (c = a; c < t; c++) begin
        dLoop[c] = (frames[fi].mode == 0);
        if (frames[fi].mode == 2) dMiso[c] = 1'b1;
        if (c > a && !eRdy[c]) dValid[c] = 1'($urandom_range(0, 1));
      end
    end
    len = t + 6;
    rxNow = startRx;
    for (int i = 0; i < NC; i++) begin
      if (eRxv[i]) rxNow = eRxNew[i];
      eRxd[i] = rxNow;
    end
    frames.delete();
  endtask

  task automatic applyStimulus(input int c);
    tx_valid = dValid[c];
    tx_data  = dData[c];
    tx_last  = dLast[c];
    misoDrv  = dMiso[c];
    loopSel  = dLoop[c];
  endtask

  task automatic runPhase(input int upto);
    for (int c = 0; c <= upto; c++) begin
      @(posedge clk);
      #1;
      applyStimulus(c);
      cyc = c;
      checkEn = 1'b1;
    end
    @(negedge clk);
    #1;
    checkEn = 1'b0;
    tx_valid = 1'b0;
  endtask

  // Compare process: every cycle of an active phase is checked against the
  // precomputed waveform. mosi may only move while sck is low.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("cs_n", cyc, 32'(cs_n), 32'(eCs[cyc]));
      checkOutput("sck", cyc, 32'(sck), 32'(eSck[cyc]));
      checkOutput("tx_ready", cyc, 32'(tx_ready), 32'(eRdy[cyc]));
      checkOutput("busy", cyc, 32'(busy), 32'(eBusy[cyc]));
      checkOutput("rx_valid", cyc, 32'(rx_valid), 32'(eRxv[cyc]));
      checkOutput("rx_data", cyc, 32'(rx_data), 32'(eRxd[cyc]));
      if (eMosiChk[cyc]) checkOutput("mosi", cyc, 32'(mosi), 32'(eMosi[cyc]));
      if (mosi !== prevMosi) checkOutput("mosiMovesWithSckHigh", cyc, 32'(sck), 32'd0);
      if (rx_valid === 1'b1) rxSeen.push_back(rx_data);
      if (recA) begin
        aCs[cyc]  = cs_n;
        aSck[cyc] = sck;
      end
    end
    prevMosi = mosi;
  end

  initial begin
    int lenA, lenB, lenC, f1, run, rises, lastRise, falls, cut, gapRun, c;
    logic [7:0] rxCarry;
    logic [7:0] expRx [8];

    for (int i = 0; i < NC; i++) begin
      aCs[i] = 1'b1;
      aSck[i] = 1'b0;
    end

    // Reset values while reset is held
    #2 reset_n = 1'b0;
    #1;
    checkOutput("rstCs", 0, 32'(cs_n), 32'd1);
    checkOutput("rstSck", 0, 32'(sck), 32'd0);
    checkOutput("rstMosi", 0, 32'(mosi), 32'd0);
    checkOutput("rstReady", 0, 32'(tx_ready), 32'd0);
    checkOutput("rstRxValid", 0, 32'(rx_valid), 32'd0);
    checkOutput("rstRxData", 0, 32'(rx_data), 32'd0);
    checkOutput("rstBusy", 0, 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checkOutput("readyBeforeFirstEdge", 0, 32'(tx_ready), 32'd0);

    // Phase A: directed frames followed by random frames
    pushFrame(1, 0, 0, 8'hA5, 8'h00, 8'h00, 0, 0);
    pushFrame(1, 0, 2, 8'h00, 8'h00, 8'h00, 0, 0);
    pushFrame(2, 0, 0, 8'h3C, 8'hC3, 8'h00, 0, 0);
    pushFrame(2, 0, 0, 8'h12, 8'h34, 8'h00, 50, 0);
    pushFrame(1, 0, 0, 8'h81, 8'h00, 8'h00, 0, 0);
    pushFrame(1, 0, 0, 8'h7E, 8'h00, 8'h00, 0, 0);
    for (int i = 0; i < 14; i++) begin
      pushFrame($urandom_range(1, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                8'($urandom), 8'($urandom), 8'($urandom),
                ($urandom_range(0, 3) == 0) ? $urandom_range(5, 12) : $urandom_range(0, 2),
                $urandom_range(0, 2));
    end
    buildTimeline(8'h00, lenA);
    recA = 1'b1;
    runPhase(lenA - 1);
    recA = 1'b0;
    rxCarry = eRxd[lenA - 1];

    // Literal pins on the first frame: cs_n low for setup+32+hold = 36
    // cycles, and eight sck rising edges four cycles apart
    f1 = -1;
    for (int i = 0; i < lenA; i++) begin
      if (aCs[i] === 1'b0) begin
        f1 = i;
        break;
      end
    end
    checkOutput("firstCsLowCycle", 0, 32'(f1), 32'd1);
    if (f1 < 1) f1 = 1;
    run = 0;
    c = f1;
    while (c < lenA && aCs[c] === 1'b0) begin
      run++;
      c++;
    end
    checkOutput("frame0CsLowLen", f1, 32'(run), 32'd36);
    rises = 0;
    lastRise = -1;
    for (int i = f1; i < f1 + run; i++) begin
      if (aSck[i] === 1'b1 && aSck[i - 1] === 1'b0) begin
        if (lastRise >= 0) checkOutput("frame0SckSpacing", i, 32'(i - lastRise), 32'd4);
        lastRise = i;
        rises++;
      end
    end
    checkOutput("frame0SckRises", f1, 32'(rises), 32'd8);

    // Literal pins on the received byte sequence of the directed frames
    expRx[0] = 8'hA5; expRx[1] = 8'hFF; expRx[2] = 8'h3C; expRx[3] = 8'hC3;
    expRx[4] = 8'h12; expRx[5] = 8'h34; expRx[6] = 8'h81; expRx[7] = 8'h7E;
    checkOutput("rxCountAtLeast8", 0, 32'(rxSeen.size() >= 8), 32'd1);
    for (int i = 0; i < 8; i++) begin
      if (i < rxSeen.size()) checkOutput("directedRx", i, 32'(rxSeen[i]), 32'(expRx[i]));
    end

    // cs_n high time between the two back-to-back single-byte frames
    falls = 0;
    gapRun = 0;
    for (int i = 1; i < lenA; i++) begin
      if (aCs[i - 1] === 1'b1 && aCs[i] === 1'b0) begin
        falls++;
        if (falls == 6) begin
          c = i - 1;
          while (c >= 0 && aCs[c] === 1'b1) begin
            gapRun++;
            c--;
          end
        end
      end
    end
    checkOutput("gapAtLeastCsGap", falls, 32'(gapRun >= CSG), 32'd1);

    // Phase B: asynchronous reset in the middle of a byte
    pushFrame(1, 1, 0, 8'($urandom) | 8'h10, 8'h00, 8'h00, 0, 0);
    buildTimeline(rxCarry, lenB);
    cut = 1 + 1 + CSS + 2 * D * 3 + D;
    runPhase(cut);
    checkOutput("preResetSckHigh", cut, 32'(sck), 32'd1);
    checkOutput("preResetMosi", cut, 32'(mosi), 32'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("midRstCs", cut, 32'(cs_n), 32'd1);
    checkOutput("midRstSck", cut, 32'(sck), 32'd0);
    checkOutput("midRstMosi", cut, 32'(mosi), 32'd0);
    checkOutput("midRstBusy", cut, 32'(busy), 32'd0);
    checkOutput("midRstRxData", cut, 32'(rx_data), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("midRstNoRxValid", i, 32'(rx_valid), 32'd0);
    end
    #1 reset_n = 1'b1;
    #1;
    checkOutput("releaseReadyLow", 0, 32'(tx_ready), 32'd0);

    // Phase C: a clean frame after the interrupted one
    rxSeen.delete();
    pushFrame(1, 0, 0, 8'h5A, 8'h00, 8'h00, 0, 0);
    buildTimeline(8'h00, lenC);
    runPhase(lenC - 1);
    checkOutput("postRstRxCount", 0, 32'(rxSeen.size()), 32'd1);
    if (rxSeen.size() > 0) checkOutput("postRstRx", 0, 32'(rxSeen[0]), 32'h5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
